lsu_mmio: RTL and testbench

LSU_MMIO -- requirements
Module: lsu_mmio

---
 rtl/lsu_mmio.sv | 207 ++++++++++++++++++++
 tb/tb_lsu_mmio.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mmio.sv
// lsu_mmio: load/store unit with a byte-strobed data RAM, output peripheral registers and a synchronized switch port.
// Optional macro LSU_MISALIGN_EN: misaligned data-memory accesses run as split two-word accesses instead of erroring.

module lsu_mmio #(
  parameter int DMEM_WORDS = 2048,
  parameter int NUM_OUT    = 8,
  parameter int OUT_W      = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [31:0]              req_addr_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [31:0]              req_wdata_i,
  output logic                     rsp_valid_o,
  output logic [31:0]              rsp_rdata_o,
  output logic                     rsp_err_o,
  input  logic [31:0]              io_sw_i,
  output logic [NUM_OUT*OUT_W-1:0] io_out_o
);

`ifdef LSU_MISALIGN_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  localparam int          AW        = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;
  localparam logic [16:0] DmemBytes = 17'(4 * DMEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_e;

  state_e             state_q, state_d;
  logic               we_q, uns_q;
  logic [15:0]        addr_q;
  logic [1:0]         size_q;
  logic [31:0]        wdata_q;
  logic               rsp_valid_q, rsp_err_q;
  logic [31:0]        lo_q;
  logic [OUT_W-1:0]   out_q [NUM_OUT];
  logic [OUT_W-1:0]   out_d [NUM_OUT];
  logic [31:0]        sw_meta_q, sw_sync_q;
  logic [31:0]        mem_q [DMEM_WORDS];
  logic [31:0]        ram_rdata_q;

  logic               unused_addr_hi;
  assign unused_addr_hi = ^req_addr_i[31:16];

  // Request decode, all from the registered request fields.
  logic [1:0]  off;
  logic [3:0]  sz_mask;
  logic        misaligned, cross_geom, in_dmem, is_out, is_sw, second_oob;
  logic        dmem_err, acc_err, crossing;
  logic [7:0]  st_be;
  logic [63:0] st_data;

  assign off        = addr_q[1:0];
  assign sz_mask    = (size_q == 2'b00) ? 4'b0001 :
                      (size_q == 2'b01) ? 4'b0011 :
                      (size_q == 2'b10) ? 4'b1111 : 4'b0000;
  assign misaligned = (size_q == 2'b01 && off[0]) || (size_q == 2'b10 && off != 2'b00);
  assign cross_geom = (size_q == 2'b01 && off == 2'b11) || (size_q == 2'b10 && off != 2'b00);
  assign in_dmem    = {1'b0, addr_q} < DmemBytes;
  assign is_out     = addr_q[15:8] == 8'h80 && addr_q[3:2] == 2'b00 &&
                      {28'd0, addr_q[7:4]} < 32'(NUM_OUT);
  assign is_sw      = addr_q[15:2] == 14'h2400;
  assign second_oob = ({18'd0, addr_q[15:2]} + 32'd1) >= 32'(DMEM_WORDS);

  assign dmem_err   = (misaligned && !MisalignEn) || (MisalignEn && cross_geom && second_oob);
  assign acc_err    = (size_q == 2'b11) ||
                      (in_dmem ? dmem_err :
                       is_out  ? misaligned :
                       is_sw   ? (we_q || misaligned) : 1'b1);
  assign crossing   = in_dmem && cross_geom && !acc_err;

  // Store bytes laid out over a two-word window: low word is addr[15:2], high word the next one.
  assign st_be      = {4'd0, sz_mask} << off;
  assign st_data    = {32'd0, wdata_q} << {off, 3'b000};

  // Data RAM port
  logic [AW-1:0] widx, ram_idx;
  logic          ram_en;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;

  assign widx      = addr_q[AW+1:2];
  assign ram_idx   = (state_q == ACC1) ? widx + AW'(1) : widx;
  assign ram_en    = in_dmem && !acc_err && (state_q == ACC0 || state_q == ACC1);
  assign ram_be    = (state_q == ACC1) ? st_be[7:4] : st_be[3:0];
  assign ram_wdata = (state_q == ACC1) ? st_data[63:32] : st_data[31:0];

  // NOTE: the data RAM has no reset; its contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (ram_en) begin
      if (we_q) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem_q[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
      ram_rdata_q <= mem_q[ram_idx];
    end
  end

  // Peripheral read value and output register update
  logic [31:0] periph_rdata, wr_mask, merged;

  assign wr_mask = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    periph_rdata = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (4'(k) == addr_q[7:4]) periph_rdata = 32'(out_q[k]);
    end
    if (is_sw) periph_rdata = sw_sync_q;
  end

  always_comb begin
    merged = '0;
    for (int k = 0; k < NUM_OUT; k++) out_d[k] = out_q[k];
    if (state_q == ACC0 && we_q && is_out && !acc_err) begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (4'(k) == addr_q[7:4]) begin
          merged   = (32'(out_q[k]) & ~wr_mask) | (st_data[31:0] & wr_mask);
          out_d[k] = merged[OUT_W-1:0];
        end
      end
    end
  end

  always_comb begin
    io_out_o = '0;
    for (int k = 0; k < NUM_OUT; k++) io_out_o[k*OUT_W +: OUT_W] = out_q[k];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid_i) state_d = ACC0;
      ACC0:    state_d = crossing ? ACC1 : RESP;
      ACC1:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      lo_q        <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
      for (int k = 0; k < NUM_OUT; k++) out_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      sw_meta_q   <= io_sw_i;
      sw_sync_q   <= sw_meta_q;
      out_q       <= out_d;
      rsp_valid_q <= (state_d == RESP);
      rsp_err_q   <= (state_d == RESP) && acc_err;
      if (state_q == IDLE && req_valid_i) begin
        we_q    <= req_we_i;
        uns_q   <= req_unsigned_i;
        addr_q  <= req_addr_i[15:0];
        size_q  <= req_size_i;
        wdata_q <= req_wdata_i;
      end
      // lo_q holds the peripheral value, or the first word of a split dmem access.
      if (state_q == ACC0 && !in_dmem) lo_q <= periph_rdata;
      if (state_q == ACC1)             lo_q <= ram_rdata_q;
    end
  end

  // Load assembly: the RAM read of the last access state lands in the RESP cycle.
  logic [63:0] ld_src;
  logic [31:0] ld_word, ld_ext;

  assign ld_src  = crossing ? {ram_rdata_q, lo_q} :
                   in_dmem  ? {32'd0, ram_rdata_q} : {32'd0, lo_q};
  assign ld_word = 32'(ld_src >> {off, 3'b000});

  always_comb begin
    ld_ext = ld_word;
    case (size_q)
      2'b00:   ld_ext = uns_q ? {24'd0, ld_word[7:0]}  : {{24{ld_word[7]}},  ld_word[7:0]};
      2'b01:   ld_ext = uns_q ? {16'd0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = (rsp_valid_q && !rsp_err_q && !we_q) ? ld_ext : 32'd0;

endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: directed vectors against a byte-level memory/peripheral model, with a per-cycle response compare.
// Expectations adapt to LSU_MISALIGN_EN when the bench is built with the same macro as the design.

module tb_lsu_mmio;

  localparam int DW = 2048;
  localparam int NO = 8;
  localparam int OW = 32;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10, SX = 2'b11;

`ifdef LSU_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  logic           req_we_i = 1'b0;
  logic [31:0]    req_addr_i = '0;
  logic [1:0]     req_size_i = '0;
  logic           req_unsigned_i = 1'b0;
  logic [31:0]    req_wdata_i = '0;
  logic           rsp_valid_o;
  logic [31:0]    rsp_rdata_o;
  logic           rsp_err_o;
  logic [31:0]    io_sw_i = '0;
  logic [NO*OW-1:0] io_out_o;

  lsu_mmio #(.DMEM_WORDS(DW), .NUM_OUT(NO), .OUT_W(OW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_size_i(req_size_i),
    .req_unsigned_i(req_unsigned_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .io_sw_i(io_sw_i), .io_out_o(io_out_o)
  );

  always #5 clk_i = ~clk_i;

  int ecount = 0;
  always @(posedge clk_i) ecount <= ecount + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: byte-addressed data memory, output registers and switch value.
  logic [7:0]  mem_m [4*DW];
  logic [31:0] out_m [NO];
  logic [31:0] sw_m = '0;

  function automatic logic [255:0] pack_out();
    logic [255:0] r;
    r = '0;
    for (int k = 0; k < NO; k++) r[k*OW +: OW] = out_m[k];
    return r;
  endfunction

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata,
                              output logic [31:0] rd, output logic err, output int lat);
    int a, n, off, k;
    logic [31:0] v;
    a = int'(addr[15:0]);
    n = 1 << size;
    off = a % 4;
    rd = '0; err = 1'b0; lat = 1; v = '0;
    if (size == SX) err = 1'b1;
    else if (a < 4*DW) begin
      if ((a % n) != 0 && !MIS) err = 1'b1;
      else if (a + n > 4*DW) err = 1'b1;
      else begin
        if (off + n > 4) lat = 2;
        for (int i = 0; i < n; i++) begin
          if (we) mem_m[a+i] = wdata[8*i +: 8];
          else    v[8*i +: 8] = mem_m[a+i];
        end
      end
    end else if (a >= 'h8000 && a < 'h8000 + 16*NO && (a % 16) < 4) begin
      k = (a - 'h8000) / 16;
      if ((a % n) != 0) err = 1'b1;
      else begin
        for (int i = 0; i < n; i++) begin
          if (we) out_m[k][8*(off+i) +: 8] = wdata[8*i +: 8];
          else    v[8*i +: 8] = out_m[k][8*(off+i) +: 8];
        end
      end
    end else if (a - off == 'h9000) begin
      if (we || (a % n) != 0) err = 1'b1;
      else for (int i = 0; i < n; i++) v[8*i +: 8] = sw_m[8*(off+i) +: 8];
    end else err = 1'b1;
    if (!err && !we) begin
      if (n == 1)      rd = uns ? {24'd0, v[7:0]}  : {{24{v[7]}},  v[7:0]};
      else if (n == 2) rd = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else             rd = v;
    end
  endtask

  typedef struct {
    int          at;
    logic [31:0] rd;
    logic        err;
    string       name;
  } exp_t;
  exp_t q[$];

  always @(negedge clk_i) begin
    if (q.size() > 0 && q[0].at == ecount) begin
      check({q[0].name, " rsp_valid"}, 256'(rsp_valid_o), 256'(1'b1));
      check({q[0].name, " rsp_rdata"}, 256'(rsp_rdata_o), 256'(q[0].rd));
      check({q[0].name, " rsp_err"},   256'(rsp_err_o),   256'(q[0].err));
      check({q[0].name, " io_out"},    256'(io_out_o),    pack_out());
      void'(q.pop_front());
    end else begin
      check("rsp_valid idle", 256'(rsp_valid_o), 256'(1'b0));
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata, output int e);
    int guard;
    @(negedge clk_i);
    req_we_i = we; req_addr_i = addr; req_size_i = size;
    req_unsigned_i = uns; req_wdata_i = wdata; req_valid_i = 1'b1;
    guard = 0;
    while (!req_ready_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    if (!req_ready_o) check("req_ready timeout", 256'(req_ready_o), 256'(1'b1));
    e = ecount + 1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
  endtask

  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                        input bit pin, input logic [31:0] lit_rd, input logic lit_err);
    logic [31:0] rd;
    logic        err;
    int          lat, e;
    exp_t        x;
    model_access(we, addr, size, uns, wdata, rd, err, lat);
    if (pin) begin
      check({name, " model rdata"}, 256'(rd), 256'(lit_rd));
      check({name, " model err"},   256'(err), 256'(lit_err));
    end
    issue(we, addr, size, uns, wdata, e);
    x.at = e + lat; x.rd = rd; x.err = err; x.name = name;
    q.push_back(x);
    for (int g = 0; g < 10 && q.size() != 0; g++) @(negedge clk_i);
    if (q.size() != 0) begin
      check({name, " response timeout"}, 256'(q.size()), 256'(0));
      q.delete();
    end
  endtask

  initial begin
    int e;
    for (int k = 0; k < NO; k++) out_m[k] = '0;
    for (int i = 0; i < 4*DW; i++) mem_m[i] = '0;

    #1;
    check("reset rsp_valid", 256'(rsp_valid_o), 256'(1'b0));
    check("reset rsp_rdata", 256'(rsp_rdata_o), 256'(0));
    check("reset rsp_err",   256'(rsp_err_o),   256'(1'b0));
    check("reset io_out",    256'(io_out_o),    256'(0));
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready after reset", 256'(req_ready_o), 256'(1'b1));

    // Data memory basics and extension
    do_req("st w 0x10",    1, 32'h0010, SW, 0, 32'hDEADBEEF, 1, 32'h0, 0);
    do_req("ld w 0x10",    0, 32'h0010, SW, 0, 32'h0, 1, 32'hDEADBEEF, 0);
    do_req("ld b 0x13 s",  0, 32'h0013, SB, 0, 32'h0, 1, 32'hFFFFFFDE, 0);
    do_req("ld b 0x13 u",  0, 32'h0013, SB, 1, 32'h0, 1, 32'h000000DE, 0);
    do_req("ld h 0x11 s",  0, 32'h0011, SH, 0, 32'h0, 1, MIS ? 32'hFFFFADBE : 32'h0, !MIS);
    do_req("ld h 0x12 u",  0, 32'h0012, SH, 1, 32'h0, 1, 32'h0000DEAD, 0);
    do_req("ld h 0x10 s",  0, 32'h0010, SH, 0, 32'h0, 1, 32'hFFFFBEEF, 0);
    do_req("st b 0x11",    1, 32'h0011, SB, 0, 32'h0000007F, 1, 32'h0, 0);
    do_req("ld w 0x10 b2b",0, 32'h0010, SW, 0, 32'h0, 1, 32'hDEAD7FEF, 0);

    // Word-crossing accesses
    do_req("st w 0x20",    1, 32'h0020, SW, 0, 32'h0, 0, 32'h0, 0);
    do_req("st w 0x24",    1, 32'h0024, SW, 0, 32'h0, 0, 32'h0, 0);
    do_req("st w 0x22",    1, 32'h0022, SW, 0, 32'h11223344, 1, 32'h0, !MIS);
    do_req("ld w 0x22",    0, 32'h0022, SW, 0, 32'h0, 1, MIS ? 32'h11223344 : 32'h0, !MIS);
    do_req("ld w 0x20",    0, 32'h0020, SW, 0, 32'h0, 1, MIS ? 32'h33440000 : 32'h0, 0);
    do_req("ld w 0x24",    0, 32'h0024, SW, 0, 32'h0, 1, MIS ? 32'h00001122 : 32'h0, 0);
    do_req("st h 0x27",    1, 32'h0027, SH, 0, 32'h0000A55A, 1, 32'h0, !MIS);
    do_req("ld h 0x27 u",  0, 32'h0027, SH, 1, 32'h0, 1, MIS ? 32'h0000A55A : 32'h0, !MIS);
    do_req("ld w 0x24 b",  0, 32'h0024, SW, 0, 32'h0, 1, MIS ? 32'h5A001122 : 32'h0, 0);

    // Top of data memory, ignored upper address bits, illegal size
    do_req("st w 0x1ffc",  1, 32'h1FFC, SW, 0, 32'hCAFEF00D, 1, 32'h0, 0);
    do_req("ld w 0x1ffc",  0, 32'h1FFC, SW, 0, 32'h0, 1, 32'hCAFEF00D, 0);
    do_req("ld w 0x1ffe",  0, 32'h1FFE, SW, 0, 32'h0, 1, 32'h0, 1);
    do_req("ld b 0x1fff",  0, 32'h1FFF, SB, 1, 32'h0, 1, 32'h000000CA, 0);
    do_req("ld w hi addr", 0, 32'hFFFF0010, SW, 0, 32'h0, 1, 32'hDEAD7FEF, 0);
    do_req("ld size 11",   0, 32'h0010, SX, 0, 32'h0, 1, 32'h0, 1);

    // Output registers
    do_req("st h 0x8010",  1, 32'h8010, SH, 0, 32'h0000ABCD, 1, 32'h0, 0);
    check("io_out reg1 literal", 256'(io_out_o[63:32]), 256'(32'h0000ABCD));
    do_req("ld w 0x8010",  0, 32'h8010, SW, 0, 32'h0, 1, 32'h0000ABCD, 0);
    do_req("st w 0x9000",  1, 32'h9000, SW, 0, 32'hFFFFFFFF, 1, 32'h0, 1);
    do_req("st b 0x8023",  1, 32'h8023, SB, 0, 32'h00000099, 1, 32'h0, 0);
    check("io_out reg2 literal", 256'(io_out_o[95:64]), 256'(32'h99000000));
    do_req("ld b 0x8023 s",0, 32'h8023, SB, 0, 32'h0, 1, 32'hFFFFFF99, 0);
    do_req("ld h 0x8011",  0, 32'h8011, SH, 0, 32'h0, 1, 32'h0, 1);
    do_req("ld w 0x8004",  0, 32'h8004, SW, 0, 32'h0, 1, 32'h0, 1);
    do_req("ld w 0x8080",  0, 32'h8080, SW, 0, 32'h0, 1, 32'h0, 1);

    // Switch input through the synchronizer
    @(negedge clk_i);
    io_sw_i = 32'h5A5A0001;
    sw_m = 32'h5A5A0001;
    repeat (2) @(negedge clk_i);
    do_req("ld w 0x9000",  0, 32'h9000, SW, 0, 32'h0, 1, 32'h5A5A0001, 0);
    do_req("ld h 0x9002 u",0, 32'h9002, SH, 1, 32'h0, 1, 32'h00005A5A, 0);
    do_req("ld w 0x7000",  0, 32'h7000, SW, 0, 32'h0, 1, 32'h0, 1);

    // Reset during ACC0 of a peripheral store aborts it
    issue(1, 32'h8000, SW, 0, 32'h12345678, e);
    rst_ni = 1'b0;
    for (int k = 0; k < NO; k++) out_m[k] = '0;
    #1;
    check("rst io_out",    256'(io_out_o),    256'(0));
    check("rst rsp_valid", 256'(rsp_valid_o), 256'(1'b0));
    check("rst rsp_rdata", 256'(rsp_rdata_o), 256'(0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("rst ready after release", 256'(req_ready_o), 256'(1'b1));
    check("rst io_out after release", 256'(io_out_o), 256'(0));
    repeat (3) @(negedge clk_i);
    do_req("ld w 0x8000 post",0, 32'h8000, SW, 0, 32'h0, 1, 32'h0, 0);
    do_req("ld w 0x8010 post",0, 32'h8010, SW, 0, 32'h0, 1, 32'h0, 0);
    do_req("ld w 0x10 post",  0, 32'h0010, SW, 0, 32'h0, 1, 32'hDEAD7FEF, 0);
    do_req("ld w 0x9000 post",0, 32'h9000, SW, 0, 32'h0, 1, 32'h5A5A0001, 0);

    repeat (3) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
